// File: rtl/pwm_seq_ctrl.sv
// Step-table sequencer for the PWM counter fre/duty inputs; retunes only on period wrap.
// Optional macro PWM_SEQ_IRQ_EN adds a sticky completion interrupt (irq/irq_clr).
module pwm_seq_ctrl #(
    parameter int         DEPTH     = 8,
    parameter int         AW        = 3,
    parameter logic [1:0] IDLE_FRE  = 2'd0,
    parameter logic [2:0] IDLE_DUTY = 3'd7
) (
    input  logic          iClk,
    input  logic          iReset_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [12:0]   wr_data,
    input  logic [AW-1:0] last_idx,
    input  logic          loop_en,
    input  logic          start,
    input  logic          stop,
`ifdef PWM_SEQ_IRQ_EN
    input  logic          irq_clr,
    output logic          irq,
`endif
    output logic [1:0]    fre_o,
    output logic [2:0]    duty_o,
    output logic          busy,
    output logic [AW-1:0] step_idx,
    output logic          period_tick,
    output logic          done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_n;
    logic [12:0]   tbl [DEPTH];
    logic [5:0]    ph, len;
    logic          wrap;
    logic [7:0]    rep_cnt, rep_n;
    logic          start_pend, start_pend_n;
    logic          stop_pend, stop_pend_n;
    logic [1:0]    fre_n;
    logic [2:0]    duty_n;
    logic [AW-1:0] idx_n, load_idx;
    logic          load, done_n;
    logic [12:0]   entry;

    always_ff @(posedge iClk) begin
        if (wr_en) tbl[wr_addr] <= wr_data;
    end

    always_comb begin
        len = 6'd5;
        unique case (fre_o)
            2'd0: len = 6'd5;
            2'd1: len = 6'd10;
            2'd2: len = 6'd25;
            2'd3: len = 6'd50;
        endcase
    end

    assign wrap        = (ph == len - 6'd1);
    assign period_tick = wrap;
    assign busy        = (state == RUN);

    always_comb begin
        state_n  = state;
        fre_n    = fre_o;
        duty_n   = duty_o;
        idx_n    = step_idx;
        rep_n    = rep_cnt;
        done_n   = 1'b0;
        load     = 1'b0;
        load_idx = '0;
        if (wrap) begin
            unique case (state)
                IDLE: begin
                    if (start_pend) begin
                        state_n = RUN;
                        idx_n   = '0;
                        load    = 1'b1;
                    end
                end
                RUN: begin
                    if (stop_pend) begin
                        state_n = IDLE;
                        fre_n   = IDLE_FRE;
                        duty_n  = IDLE_DUTY;
                    end else if (rep_cnt != 8'd0) begin
                        rep_n = rep_cnt - 8'd1;
                    end else if (step_idx != last_idx) begin
                        idx_n    = step_idx + 1'b1;
                        load_idx = step_idx + 1'b1;
                        load     = 1'b1;
                    end else if (loop_en) begin
                        idx_n = '0;
                        load  = 1'b1;
                    end else begin
                        state_n = IDLE;
                        fre_n   = IDLE_FRE;
                        duty_n  = IDLE_DUTY;
                        idx_n   = '0;
                        done_n  = 1'b1;
                    end
                end
            endcase
        end
        // Table read is combinational so the edge loads pre-write contents.
        entry = tbl[load_idx];
        if (load) begin
            fre_n  = entry[4:3];
            duty_n = entry[2:0];
            rep_n  = entry[12:5];
        end
    end

    always_comb begin
        start_pend_n = start_pend;
        stop_pend_n  = stop_pend;
        if (state == IDLE) begin
            stop_pend_n = 1'b0;
            if (wrap && start_pend) start_pend_n = 1'b0;
            else if (stop)          start_pend_n = 1'b0;
            else if (start)         start_pend_n = 1'b1;
        end else begin
            start_pend_n = 1'b0;
            if (wrap)      stop_pend_n = (state_n == RUN) && stop;
            else if (stop) stop_pend_n = 1'b1;
        end
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state      <= IDLE;
            ph         <= 6'd0;
            fre_o      <= IDLE_FRE;
            duty_o     <= IDLE_DUTY;
            step_idx   <= '0;
            rep_cnt    <= 8'd0;
            start_pend <= 1'b0;
            stop_pend  <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            ph         <= wrap ? 6'd0 : ph + 6'd1;
            fre_o      <= fre_n;
            duty_o     <= duty_n;
            step_idx   <= idx_n;
            rep_cnt    <= rep_n;
            start_pend <= start_pend_n;
            stop_pend  <= stop_pend_n;
            done       <= done_n;
        end
    end

`ifdef PWM_SEQ_IRQ_EN
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n)    irq <= 1'b0;
        else if (done_n)  irq <= 1'b1;
        else if (irq_clr) irq <= 1'b0;
    end
`endif

endmodule

// File: doc/pwm_seq_ctrl.md
Name: pwm_seq_ctrl

Overview:
- Sequencer driving the fre/duty configuration inputs of the PWM counter block.
- Plays a programmed table of steps. Each step is {fre, duty, repeat count}.
- Changes settings only on the exact clock edge where the downstream period counter wraps to 0, so the counter never sees a mid-period length change.
- Runs a mirror phase counter that stays lock-step with the downstream counter, because both share iClk and iReset_n.

Parameters:
- DEPTH, 8, number of step-table entries (power of two, 2..16).
- AW, 3, step index width, equal to log2(DEPTH).
- IDLE_FRE, 2'd0, fre_o value driven while idle.
- IDLE_DUTY, 3'd7, duty_o value driven while idle (duty code >=5 selects the 0% setting).

Ports:
- iClk  in  1  clock
- iReset_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  step-table write strobe
- wr_addr  in  AW  table entry to write
- wr_data  in  13  {reps[12:5], fre[4:3], duty[2:0]}
- last_idx  in  AW  index of the final step in the sequence
- loop_en  in  1  1 = restart at step 0 after last_idx
- start  in  1  one-cycle start request
- stop  in  1  one-cycle stop request
- fre_o  out  2  to PWM counter fre
- duty_o  out  3  to PWM counter duty
- busy  out  1  state is RUN
- step_idx  out  AW  current step
- period_tick  out  1  high in the last cycle of each period
- done  out  1  one-cycle pulse at sequence completion

Behaviour:
- Period length len(fre_o): 0→5, 1→10, 2→25, 3→50 clocks.
- Mirror phase counter ph[5:0]:
  - Reset value 0.
  - Next value: ph <= (ph==len-1) ? 0 : ph+1.
  - Counts continuously in every state.
- wrap = (ph == len(fre_o)-1). period_tick = wrap (decoded from registers, no latch).
- Table:
  - DEPTH x 13 registers, not reset, written on wr_en.
  - A load reads pre-edge contents. A write to the entry being loaded on the same edge takes effect only on its next load.
- Reset values: state IDLE, fre_o=IDLE_FRE, duty_o=IDLE_DUTY, step_idx=0, rep_cnt=0, start_pend=0, stop_pend=0, busy=0, done=0.
- States: IDLE, RUN. All state and output updates except start_pend/stop_pend capture occur only on a wrap edge.
- Pending flags:
  - start in IDLE sets start_pend.
  - start in RUN is ignored.
  - stop in RUN sets stop_pend.
  - stop in IDLE clears start_pend.
  - start and stop in the same cycle: stop wins.
- IDLE, wrap edge with start_pend=1:
  - Go to RUN, step_idx=0.
  - Load fre_o/duty_o/rep_cnt from entry 0.
  - Clear start_pend.
- RUN, wrap edge, evaluated in this priority:
  1. stop_pend: go to IDLE, drive idle settings, clear stop_pend, no done pulse.
  2. rep_cnt!=0: rep_cnt decrements, settings held.
  3. step_idx!=last_idx: step_idx+1, load that entry.
  4. loop_en=1: step_idx=0, load entry 0.
  5. Otherwise: go to IDLE, drive idle settings, step_idx=0, done=1 for exactly one cycle.
- A step therefore lasts (reps+1) periods of its own length. reps=255 gives 256 periods.
- last_idx and loop_en are sampled at each wrap edge. Changing them mid-run is legal.
- Reset asserted mid-run returns all state to reset values immediately. ph and the downstream counter stay aligned because they share the reset.

Optional Feature:
- Macro: PWM_SEQ_IRQ_EN.
- Defined:
  - Adds ports irq (out, 1) and irq_clr (in, 1).
  - irq sets on any done pulse and holds until irq_clr.
  - Set and clear in the same cycle: set wins.
  - irq resets to 0.
- Undefined: the ports are absent and the logic is not built. Behaviour is otherwise identical.

Test Plan:
- Release reset, no start -> fre_o=0, duty_o=7, period_tick pulses every 5 cycles, busy=0.
- Program e0={reps=1,fre=1,duty=2}, e1={reps=0,fre=3,duty=0}, last_idx=1, loop_en=0; pulse start -> at next wrap fre_o=1/duty_o=2 for 20 cycles, then fre_o=3/duty_o=0 for 50 cycles, then done pulses once and idle settings return.
- Same program with loop_en=1 -> after e1 the sequence returns to e0 and busy stays 1; pulse stop mid-e1 -> outputs hold until the 50-cycle period ends, then idle settings, no done pulse.
- start and stop asserted together in IDLE -> sequence never starts.
- Write e0 on the same edge as its load -> old value is used on this pass, new value on the next loop.
- Assert iReset_n low mid-step -> all outputs return to reset values immediately; with PWM_SEQ_IRQ_EN defined, irq sets at done and clears on irq_clr.
